// File: rtl/prng_share_ctrl.sv
// prng_share_ctrl
// ---------------
// Owns the 128-bit LFSR mask generator and shares its 64-bit output among
// N_REQ masked-crypto requesters.
//
// Life cycle of one seed:
//   SEED_WAIT : take a 128-bit word from the entropy source. An all-zero word
//               would lock the LFSR up, so it is consumed and flagged instead.
//   WARMUP    : step the LFSR WARMUP times and throw the output away.
//   SERVE     : hand the current LFSR word to one requester (round-robin).
//   ADVANCE   : step the LFSR so that STEP steps separate delivered words.
// After RESEED_INTERVAL delivered words, or on a software reseed request,
// the controller goes back to SEED_WAIT the next time it reaches SERVE.
//
// Handshakes:
//   Entropy: a word transfers in any cycle where ent_valid_i && ent_ready_o.
//   Requesters: req_i[k] is a level held until gnt_o[k] is seen. The grant is
//   combinational, rnd_o carries the word in that same cycle, and one grant
//   consumes exactly one word.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   ent_valid_i      entropy word valid
//   ent_data_i       entropy seed word
//   ent_ready_o      entropy word accepted when valid & ready
//   reseed_req_i     software reseed pulse (ignored while already in SEED_WAIT)
//   prng_init_o      generator init (load seed)
//   prng_en_o        generator step enable
//   prng_seed_o      generator seed (straight from ent_data_i)
//   prng_data_i      generator 64-bit output
//   req_i            per-requester level request
//   gnt_o            one-hot grant
//   rnd_o            random word in the grant cycle, 0 otherwise
//   seeded_o         high in SERVE / ADVANCE
//   seed_err_o       one-cycle pulse when an all-zero seed is rejected
//   dbg_state_o      current FSM state, for debug and checker binding
module prng_share_ctrl #(
  parameter int N_REQ           = 4,
  parameter int WARMUP          = 128,
  parameter int STEP            = 64,
  parameter int RESEED_INTERVAL = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ent_valid_i,
  input  logic [127:0]      ent_data_i,
  output logic              ent_ready_o,
  input  logic              reseed_req_i,
  output logic              prng_init_o,
  output logic              prng_en_o,
  output logic [127:0]      prng_seed_o,
  input  logic [63:0]       prng_data_i,
  input  logic [N_REQ-1:0]  req_i,
  output logic [N_REQ-1:0]  gnt_o,
  output logic [63:0]       rnd_o,
  output logic              seeded_o,
  output logic              seed_err_o,
  output logic [1:0]        dbg_state_o
);

  localparam int WARM_W = $clog2(WARMUP + 1);
  localparam int STEP_W = $clog2(STEP + 1);
  localparam int WORD_W = $clog2(RESEED_INTERVAL + 1);
  localparam int PTR_W  = $clog2(N_REQ);

  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP - 1);
  localparam logic [STEP_W-1:0] STRIDE_LD = STEP_W'(STEP - 1);
  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(RESEED_INTERVAL - 1);

  typedef enum logic [1:0] {
    ST_SEED_WAIT = 2'd0,
    ST_WARMUP    = 2'd1,
    ST_SERVE     = 2'd2,
    ST_ADVANCE   = 2'd3
  } state_t;

  state_t              state;
  logic                rst_done;        // low until the first clock after reset release
  logic [WARM_W-1:0]   warm_cnt;
  logic [STEP_W-1:0]   stride_cnt;
  logic [WORD_W-1:0]   word_cnt;
  logic [PTR_W-1:0]    ptr;             // last granted requester
  logic                reseed_pending;

  logic                seed_take;
  logic                seed_zero;
  logic                serve_open;
  logic                pick_any;
  logic [PTR_W-1:0]    pick_idx;
  logic [PTR_W-1:0]    cand;
  logic                grant;

  // ---------------------------------------------------------------------------
  // Entropy side. ent_ready_o stays low while reset is held and for the
  // release cycle, so no seed can slip in before the controller is running.
  // ---------------------------------------------------------------------------
  assign ent_ready_o = (state == ST_SEED_WAIT) && rst_done;
  assign seed_take   = ent_ready_o && ent_valid_i;
  assign seed_zero   = (ent_data_i == '0);
  assign prng_init_o = seed_take && !seed_zero;
  assign seed_err_o  = seed_take && seed_zero;
  assign prng_seed_o = ent_data_i;

  // ---------------------------------------------------------------------------
  // Round-robin pick: first requester at or after ptr+1, wrapping.
  // ---------------------------------------------------------------------------
  always_comb begin
    pick_any = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = PTR_W'((int'(ptr) + i) % N_REQ);
      if (!pick_any && req_i[cand]) begin
        pick_any = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // A pending reseed blocks grants in SERVE; the word is not handed out.
  assign serve_open = (state == ST_SERVE) && !reseed_pending;
  assign grant      = serve_open && pick_any;

  always_comb begin
    gnt_o = '0;
    if (grant) gnt_o[pick_idx] = 1'b1;
  end

  assign rnd_o = grant ? prng_data_i : 64'd0;

  // The grant cycle itself is the first of the STEP steps for that word.
  // init is only raised in SEED_WAIT where en is never raised.
  assign prng_en_o   = (state == ST_WARMUP) || (state == ST_ADVANCE) || grant;
  assign seeded_o    = (state == ST_SERVE) || (state == ST_ADVANCE);
  assign dbg_state_o = state;

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_SEED_WAIT;
      rst_done       <= 1'b0;
      warm_cnt       <= '0;
      stride_cnt     <= '0;
      word_cnt       <= '0;
      ptr            <= PTR_W'(N_REQ - 1);
      reseed_pending <= 1'b0;
    end else begin
      rst_done <= 1'b1;

      // Software reseed is latched here and acted on at the next SERVE, so an
      // in-flight stride always completes. In SEED_WAIT a seed is already due.
      if (reseed_req_i && (state != ST_SEED_WAIT)) reseed_pending <= 1'b1;

      case (state)
        ST_SEED_WAIT: begin
          if (prng_init_o) begin
            warm_cnt <= '0;
            state    <= ST_WARMUP;
          end
        end

        ST_WARMUP: begin
          if (warm_cnt == WARM_LAST) begin
            state <= ST_SERVE;
          end else begin
            warm_cnt <= warm_cnt + 1'b1;
          end
        end

        ST_SERVE: begin
          if (reseed_pending) begin
            // Clearing wins over a reseed_req_i arriving this same cycle.
            word_cnt       <= '0;
            reseed_pending <= 1'b0;
            state          <= ST_SEED_WAIT;
          end else if (pick_any) begin
            ptr      <= pick_idx;
            word_cnt <= word_cnt + 1'b1;
            if (word_cnt == WORD_LAST) reseed_pending <= 1'b1;
            if (STEP > 1) begin
              stride_cnt <= STRIDE_LD;
              state      <= ST_ADVANCE;
            end
          end
        end

        ST_ADVANCE: begin
          stride_cnt <= stride_cnt - 1'b1;
          if (stride_cnt == STEP_W'(1)) state <= ST_SERVE;
        end

        default: state <= ST_SEED_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_prng_share_ctrl.sv
// Bench for prng_share_ctrl. Instance A: N_REQ=4, WARMUP=128, STEP=64,
// RESEED_INTERVAL=4. Instance B: N_REQ=4, WARMUP=2, STEP=1. Each instance
// drives a behavioural 128-bit LFSR; expected words come from stepping the
// seed with the same step function an independent number of times.
module tb_prng_share_ctrl;

  localparam int WARM_A = 128;
  localparam int STEP_A = 64;
  localparam int RI_A   = 4;
  localparam int WARM_B = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- instance A signals ----------------
  logic         ent_valid_a, ent_ready_a, reseed_a, init_a, en_a, seeded_a, err_a;
  logic [127:0] ent_data_a, seed_a, gen_a;
  logic [63:0]  prng_data_a, rnd_a;
  logic [3:0]   req_a, gnt_a;
  logic [1:0]   dbg_a;

  // ---------------- instance B signals ----------------
  logic         ent_valid_b, ent_ready_b, reseed_b, init_b, en_b, seeded_b, err_b;
  logic [127:0] ent_data_b, seed_b, gen_b;
  logic [63:0]  prng_data_b, rnd_b;
  logic [3:0]   req_b, gnt_b;
  logic [1:0]   dbg_b;

  prng_share_ctrl #(.N_REQ(4), .WARMUP(WARM_A), .STEP(STEP_A), .RESEED_INTERVAL(RI_A)) dut_a (
    .clk(clk), .rst(rst),
    .ent_valid_i(ent_valid_a), .ent_data_i(ent_data_a), .ent_ready_o(ent_ready_a),
    .reseed_req_i(reseed_a),
    .prng_init_o(init_a), .prng_en_o(en_a), .prng_seed_o(seed_a), .prng_data_i(prng_data_a),
    .req_i(req_a), .gnt_o(gnt_a), .rnd_o(rnd_a),
    .seeded_o(seeded_a), .seed_err_o(err_a), .dbg_state_o(dbg_a)
  );

  prng_share_ctrl #(.N_REQ(4), .WARMUP(WARM_B), .STEP(1), .RESEED_INTERVAL(1024)) dut_b (
    .clk(clk), .rst(rst),
    .ent_valid_i(ent_valid_b), .ent_data_i(ent_data_b), .ent_ready_o(ent_ready_b),
    .reseed_req_i(reseed_b),
    .prng_init_o(init_b), .prng_en_o(en_b), .prng_seed_o(seed_b), .prng_data_i(prng_data_b),
    .req_i(req_b), .gnt_o(gnt_b), .rnd_o(rnd_b),
    .seeded_o(seeded_b), .seed_err_o(err_b), .dbg_state_o(dbg_b)
  );

  // ---------------- reference LFSR ----------------
  function automatic logic [127:0] lfsr_step(input logic [127:0] s);
    return {s[126:0], s[127] ^ s[125] ^ s[100] ^ s[98]};
  endfunction

  function automatic logic [63:0] lfsr_word(input logic [127:0] s, input int n);
    logic [127:0] t;
    t = s;
    for (int i = 0; i < n; i++) t = lfsr_step(t);
    return t[63:0];
  endfunction

  // Generator stand-ins driven by the controllers.
  always @(posedge clk or posedge rst) begin
    if (rst) gen_a <= '0;
    else if (init_a) gen_a <= seed_a;
    else if (en_a) gen_a <= lfsr_step(gen_a);
  end
  always @(posedge clk or posedge rst) begin
    if (rst) gen_b <= '0;
    else if (init_b) gen_b <= seed_b;
    else if (en_b) gen_b <= lfsr_step(gen_b);
  end
  assign prng_data_a = gen_a[63:0];
  assign prng_data_b = gen_b[63:0];

  // ---------------- driver helper ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (ent_ready_a !== 1'b0) begin failures++; $display("FAIL reset_ent_ready got=%0h exp=0", ent_ready_a); end
    checks++; if (gnt_a !== 4'b0) begin failures++; $display("FAIL reset_gnt got=%0h exp=0", gnt_a); end
    checks++; if (rnd_a !== 64'd0) begin failures++; $display("FAIL reset_rnd got=%0h exp=0", rnd_a); end
    checks++; if ({init_a, en_a, seeded_a, err_a} !== 4'b0) begin failures++; $display("FAIL reset_ctrl got=%0b exp=0000", {init_a, en_a, seeded_a, err_a}); end
    checks++; if (dbg_a !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_a); end
    @(posedge clk); #1 rst = 1'b0;
    tick();
    @(negedge clk);
    checks++; if (ent_ready_a !== 1'b1) begin failures++; $display("FAIL post_reset_ent_ready_a got=%0h exp=1", ent_ready_a); end
    checks++; if (ent_ready_b !== 1'b1) begin failures++; $display("FAIL post_reset_ent_ready_b got=%0h exp=1", ent_ready_b); end
  endtask

  task automatic test_step1();
    int n;
    logic [3:0] exp_g[4];
    exp_g = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
    tick(); ent_valid_b = 1'b1; ent_data_b = 128'hC0FFEE;
    @(negedge clk);
    checks++; if (init_b !== 1'b1) begin failures++; $display("FAIL step1_init got=%0h exp=1", init_b); end
    tick(); ent_valid_b = 1'b0; req_b = 4'b0101;
    n = 0;
    @(negedge clk);
    while (gnt_b === 4'b0 && n < 20) begin n++; @(negedge clk); end
    checks++; if (n !== WARM_B) begin failures++; $display("FAIL step1_warmup_len got=%0d exp=%0d", n, WARM_B); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (gnt_b !== exp_g[k]) begin failures++; $display("FAIL step1_gnt%0d got=%0b exp=%0b", k, gnt_b, exp_g[k]); end
      checks++; if (rnd_b !== lfsr_word(128'hC0FFEE, WARM_B + k)) begin failures++; $display("FAIL step1_rnd%0d got=%0h exp=%0h", k, rnd_b, lfsr_word(128'hC0FFEE, WARM_B + k)); end
      checks++; if (en_b !== 1'b1) begin failures++; $display("FAIL step1_en%0d got=%0h exp=1", k, en_b); end
      @(negedge clk);
    end
    tick(); req_b = 4'b0;
    @(negedge clk);
    checks++; if ({gnt_b, en_b} !== 5'b0) begin failures++; $display("FAIL step1_idle got=%0b exp=0", {gnt_b, en_b}); end
  endtask

  task automatic test_zero_seed();
    int n, bad;
    tick(); ent_valid_a = 1'b1; ent_data_a = '0;
    @(negedge clk);
    checks++; if (err_a !== 1'b1) begin failures++; $display("FAIL zero_seed_err got=%0h exp=1", err_a); end
    checks++; if (init_a !== 1'b0) begin failures++; $display("FAIL zero_seed_init got=%0h exp=0", init_a); end
    tick(); ent_data_a = 128'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (ent_ready_a !== 1'b1) begin failures++; $display("FAIL zero_seed_ready got=%0h exp=1", ent_ready_a); end
    checks++; if ({init_a, err_a, en_a} !== 3'b100) begin failures++; $display("FAIL good_seed_ctrl got=%0b exp=100", {init_a, err_a, en_a}); end
    tick(); ent_valid_a = 1'b0; ent_data_a = '0;
    n = 0; bad = 0;
    @(negedge clk);
    while (en_a === 1'b1 && n < 300) begin
      if (gnt_a !== 4'b0 || ent_ready_a !== 1'b0 || init_a !== 1'b0 || seeded_a !== 1'b0) bad++;
      n++;
      @(negedge clk);
    end
    checks++; if (n !== WARM_A) begin failures++; $display("FAIL warmup_len got=%0d exp=%0d", n, WARM_A); end
    checks++; if (bad !== 0) begin failures++; $display("FAIL warmup_quiet got=%0d exp=0", bad); end
    checks++; if (seeded_a !== 1'b1) begin failures++; $display("FAIL seeded_rise got=%0h exp=1", seeded_a); end
    checks++; if (dbg_a !== 2'd2) begin failures++; $display("FAIL serve_state got=%0d exp=2", dbg_a); end
  endtask

  task automatic test_round_robin();
    int gap, nz;
    nz = 0;
    tick(); req_a = 4'b1111;
    for (int w = 0; w < 4; w++) begin
      gap = 0;
      @(negedge clk);
      while (gnt_a === 4'b0 && gap < 200) begin
        if (rnd_a !== 64'd0) nz++;
        gap++;
        @(negedge clk);
      end
      checks++; if (gnt_a !== (4'b0001 << w)) begin failures++; $display("FAIL rr_gnt%0d got=%0b exp=%0b", w, gnt_a, 4'b0001 << w); end
      checks++; if (rnd_a !== lfsr_word(128'hDEAD_BEEF, WARM_A + STEP_A * w)) begin failures++; $display("FAIL rr_rnd%0d got=%0h exp=%0h", w, rnd_a, lfsr_word(128'hDEAD_BEEF, WARM_A + STEP_A * w)); end
      if (w > 0) begin
        checks++; if (gap !== STEP_A - 1) begin failures++; $display("FAIL rr_spacing%0d got=%0d exp=%0d", w, gap + 1, STEP_A); end
      end
    end
    checks++; if (nz !== 0) begin failures++; $display("FAIL rr_rnd_zero got=%0d exp=0", nz); end
  endtask

  task automatic test_reseed_boundary();
    int n, extra;
    n = 0; extra = 0;
    @(negedge clk);
    while (ent_ready_a !== 1'b1 && n < 200) begin
      if (gnt_a !== 4'b0 || rnd_a !== 64'd0) extra++;
      n++;
      @(negedge clk);
    end
    checks++; if (n !== STEP_A) begin failures++; $display("FAIL boundary_delay got=%0d exp=%0d", n, STEP_A); end
    checks++; if (extra !== 0) begin failures++; $display("FAIL boundary_no_5th got=%0d exp=0", extra); end
    checks++; if (seeded_a !== 1'b0) begin failures++; $display("FAIL boundary_seeded got=%0h exp=0", seeded_a); end
    checks++; if (dbg_a !== 2'd0) begin failures++; $display("FAIL boundary_state got=%0d exp=0", dbg_a); end
  endtask

  task automatic test_resume();
    int n;
    tick(); ent_valid_a = 1'b1; ent_data_a = 128'h1;
    @(negedge clk);
    checks++; if ({init_a, en_a} !== 2'b10) begin failures++; $display("FAIL resume_init got=%0b exp=10", {init_a, en_a}); end
    tick(); ent_valid_a = 1'b0;
    n = 0;
    @(negedge clk);
    while (gnt_a === 4'b0 && n < 300) begin n++; @(negedge clk); end
    checks++; if (n !== WARM_A) begin failures++; $display("FAIL resume_latency got=%0d exp=%0d", n, WARM_A); end
    checks++; if (gnt_a !== 4'b0001) begin failures++; $display("FAIL resume_gnt got=%0b exp=0001", gnt_a); end
    checks++; if (rnd_a !== lfsr_word(128'h1, WARM_A)) begin failures++; $display("FAIL resume_rnd got=%0h exp=%0h", rnd_a, lfsr_word(128'h1, WARM_A)); end
  endtask

  task automatic test_reseed_mid_advance();
    int n;
    tick(); req_a = 4'b0; reseed_a = 1'b1;
    tick(); reseed_a = 1'b0;
    n = 0;
    @(negedge clk);
    while (en_a === 1'b1 && n < 200) begin n++; @(negedge clk); end
    checks++; if (n !== STEP_A - 2) begin failures++; $display("FAIL stride_complete got=%0d exp=%0d", n, STEP_A - 2); end
    checks++; if ({dbg_a, gnt_a} !== {2'd2, 4'b0}) begin failures++; $display("FAIL stride_end_serve got=%0h exp=20", {dbg_a, gnt_a}); end
    @(negedge clk);
    checks++; if ({ent_ready_a, dbg_a} !== 3'b100) begin failures++; $display("FAIL soft_reseed_wait got=%0b exp=100", {ent_ready_a, dbg_a}); end
  endtask

  task automatic test_async_reset();
    tick(); ent_valid_a = 1'b1; ent_data_a = 128'h5;
    @(negedge clk);
    checks++; if (init_a !== 1'b1) begin failures++; $display("FAIL rst_seed_init got=%0h exp=1", init_a); end
    tick(); ent_valid_a = 1'b0; req_a = 4'b1111;
    repeat (10) @(negedge clk);
    checks++; if (en_a !== 1'b1) begin failures++; $display("FAIL rst_pre_en got=%0h exp=1", en_a); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({ent_ready_a, init_a, en_a, seeded_a, err_a} !== 5'b0) begin failures++; $display("FAIL rst_mid_ctrl got=%0b exp=0", {ent_ready_a, init_a, en_a, seeded_a, err_a}); end
    checks++; if ({gnt_a, rnd_a} !== 68'd0) begin failures++; $display("FAIL rst_mid_grant got=%0h exp=0", {gnt_a, rnd_a}); end
    checks++; if (dbg_a !== 2'd0) begin failures++; $display("FAIL rst_mid_state got=%0d exp=0", dbg_a); end
    @(posedge clk); #1 rst = 1'b0; req_a = 4'b0;
    tick();
    @(negedge clk);
    checks++; if ({ent_ready_a, en_a, dbg_a} !== 4'b1000) begin failures++; $display("FAIL rst_after got=%0b exp=1000", {ent_ready_a, en_a, dbg_a}); end
  endtask

  task automatic test_reseed_ignored_in_seed_wait();
    int n;
    tick(); reseed_a = 1'b1;
    tick(); reseed_a = 1'b0; ent_valid_a = 1'b1; ent_data_a = 128'h9;
    tick(); ent_valid_a = 1'b0; req_a = 4'b0010;
    n = 0;
    @(negedge clk);
    while (gnt_a === 4'b0 && n < 300) begin n++; @(negedge clk); end
    checks++; if (gnt_a !== 4'b0010) begin failures++; $display("FAIL ignore_gnt got=%0b exp=0010", gnt_a); end
    checks++; if (rnd_a !== lfsr_word(128'h9, WARM_A)) begin failures++; $display("FAIL ignore_rnd got=%0h exp=%0h", rnd_a, lfsr_word(128'h9, WARM_A)); end
    tick(); req_a = 4'b0; reseed_a = 1'b1;
    tick(); reseed_a = 1'b0;
    n = 0;
    @(negedge clk);
    while (ent_ready_a !== 1'b1 && n < 200) begin n++; @(negedge clk); end
    checks++; if (ent_ready_a !== 1'b1) begin failures++; $display("FAIL ignore_back_to_wait got=%0h exp=1", ent_ready_a); end
  endtask

  task automatic test_reseed_in_warmup();
    int n, extra;
    tick(); ent_valid_a = 1'b1; ent_data_a = 128'hA;
    tick(); ent_valid_a = 1'b0; reseed_a = 1'b1; req_a = 4'b0010;
    tick(); reseed_a = 1'b0;
    n = 0; extra = 0;
    @(negedge clk);
    while (ent_ready_a !== 1'b1 && n < 300) begin
      if (gnt_a !== 4'b0) extra++;
      n++;
      @(negedge clk);
    end
    checks++; if (n !== WARM_A) begin failures++; $display("FAIL warmup_reseed_delay got=%0d exp=%0d", n, WARM_A); end
    checks++; if (extra !== 0) begin failures++; $display("FAIL warmup_reseed_no_gnt got=%0d exp=0", extra); end
    tick(); req_a = 4'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- sequence ----------------
  initial begin
    ent_valid_a = 1'b0; ent_data_a = '0; reseed_a = 1'b0; req_a = '0;
    ent_valid_b = 1'b0; ent_data_b = '0; reseed_b = 1'b0; req_b = '0;
    test_reset();
    test_step1();
    test_zero_seed();
    test_round_robin();
    test_reseed_boundary();
    test_resume();
    test_reseed_mid_advance();
    test_async_reset();
    test_reseed_ignored_in_seed_wait();
    test_reseed_in_warmup();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
